controlo_barreira: RTL and testbench

Entry-gate controller feeding the vehicle-counting stage. It accepts plate reads from the camera and drives the barrier FSM through open, passage and close. It also keeps the time-of-day and day-of-week counters. Outputs `matricula`, `barreira`, `tempo` and `dias` connect directly to the counter's plate, barrier, time and day inputs.

---
 rtl/parque_pkg.sv | 26 ++
 rtl/controlo_barreira_if.sv | 26 ++
 rtl/relogio_semana.sv | 58 +++++
 rtl/controlo_barreira.sv | 123 ++++++++++++
 tb/tb_controlo_barreira.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/parque_pkg.sv
// Shared types and widths for the car-park entry stage: barrier FSM states,
// bus widths, day-of-week bounds and a counter-width helper.
package parque_pkg;

  localparam int PLATE_W = 24;
  localparam int TEMPO_W = 7;
  localparam int DIA_W   = 3;

  localparam logic [DIA_W-1:0] DIA_PRIMEIRO = 3'd1;
  localparam logic [DIA_W-1:0] DIA_ULTIMO   = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    PASSING = 2'd2,
    HOLD    = 2'd3
  } estado_barreira_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int largura(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/controlo_barreira_if.sv
// Camera/sensor/counter-side bundle of the entry-gate controller.
// master = stimulus side (camera, loop sensor); slave = the controller.
interface controlo_barreira_if;
  import parque_pkg::*;

  logic                 plate_valid;
  logic [PLATE_W-1:0]   plate_in;
  logic                 sensor;
  logic                 plate_ready;
  logic [PLATE_W-1:0]   matricula;
  logic                 barreira;
  logic [TEMPO_W-1:0]   tempo;
  logic [DIA_W-1:0]     dias;
  logic                 rejeitada;

  modport master (
    output plate_valid, plate_in, sensor,
    input  plate_ready, matricula, barreira, tempo, dias, rejeitada
  );

  modport slave (
    input  plate_valid, plate_in, sensor,
    output plate_ready, matricula, barreira, tempo, dias, rejeitada
  );

endinterface

// File: rtl/relogio_semana.sv
// Time-of-day and day-of-week keeper: prescaler divides clk into tempo units,
// tempo wraps at DAY_LEN and advances dias through 1..7.
module relogio_semana
  import parque_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 50_000_000,
  parameter int DAY_LEN        = 96
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [TEMPO_W-1:0] tempo,
  output logic [DIA_W-1:0]   dias
);

  localparam int PRESC_W = largura(TICKS_PER_UNIT - 1);

  if (DAY_LEN < 2 || DAY_LEN > 128 || TICKS_PER_UNIT < 1) begin : g_param_invalido
    $error("relogio_semana: DAY_LEN must be 2..128 and TICKS_PER_UNIT >= 1");
  end

  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [TEMPO_W-1:0] tempo_reg, tempo_next;
  logic [DIA_W-1:0]   dias_reg,  dias_next;
  logic               tick;

  assign tick = (presc_reg == PRESC_W'(TICKS_PER_UNIT - 1));

  always_comb begin
    presc_next = presc_reg + PRESC_W'(1);
    tempo_next = tempo_reg;
    dias_next  = dias_reg;
    if (tick) begin
      presc_next = '0;
      if (tempo_reg == TEMPO_W'(DAY_LEN - 1)) begin
        tempo_next = '0;
        dias_next  = (dias_reg == DIA_ULTIMO) ? DIA_PRIMEIRO : dias_reg + DIA_W'(1);
      end else begin
        tempo_next = tempo_reg + TEMPO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      tempo_reg <= '0;
      dias_reg  <= DIA_PRIMEIRO;
    end else begin
      presc_reg <= presc_next;
      tempo_reg <= tempo_next;
      dias_reg  <= dias_next;
    end
  end

  assign tempo = tempo_reg;
  assign dias  = dias_reg;

endmodule

// File: rtl/controlo_barreira.sv
// Entry-gate controller: accepts plate reads, runs the barrier FSM
// (IDLE/OPEN/PASSING/HOLD) and hosts the week clock. Optional OPEN timeout: OPEN_TIMEOUT_EN.
module controlo_barreira
  import parque_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 50_000_000,
  parameter int DAY_LEN        = 96,
  parameter int OPEN_HOLD      = 100,
  parameter int OPEN_TIMEOUT   = 500_000_000
) (
  input logic                clk,
  input logic                rst_n,
  controlo_barreira_if.slave bus
);

`ifdef OPEN_TIMEOUT_EN
  localparam int CNT_MAX = (OPEN_HOLD > OPEN_TIMEOUT - 1) ? OPEN_HOLD : OPEN_TIMEOUT - 1;
`else
  localparam int CNT_MAX = OPEN_HOLD;
`endif
  localparam int CNT_W = largura(CNT_MAX);

  if (OPEN_HOLD < 0 || OPEN_TIMEOUT < 1) begin : g_param_invalido
    $error("controlo_barreira: OPEN_HOLD must be >= 0 and OPEN_TIMEOUT >= 1");
  end

  estado_barreira_t   state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [PLATE_W-1:0] matricula_reg, matricula_next;
  logic               barreira_reg, barreira_next;
  logic               plate_ready_reg, plate_ready_next;
  logic               rejeitada_reg, rejeitada_next;
  logic [TEMPO_W-1:0] tempo_w;
  logic [DIA_W-1:0]   dias_w;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    matricula_next = matricula_reg;
    rejeitada_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.plate_valid) begin
          if (bus.plate_in != '0) begin
            matricula_next = bus.plate_in;
            state_next     = OPEN;
`ifdef OPEN_TIMEOUT_EN
            cnt_next       = CNT_W'(OPEN_TIMEOUT - 1);
`endif
          end else begin
            rejeitada_next = 1'b1;
          end
        end
      end
      OPEN: begin
        if (bus.sensor) begin
          state_next = PASSING;
`ifdef OPEN_TIMEOUT_EN
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
`endif
        end
      end
      PASSING: begin
        if (!bus.sensor) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(OPEN_HOLD);
        end
      end
      HOLD: begin
        // A vehicle re-entering the loop reopens the passage; the hold restarts on its exit.
        if (bus.sensor) begin
          state_next = PASSING;
        end else if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    barreira_next    = (state_next == IDLE);
    plate_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      matricula_reg   <= '0;
      barreira_reg    <= 1'b1;
      plate_ready_reg <= 1'b1;
      rejeitada_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      matricula_reg   <= matricula_next;
      barreira_reg    <= barreira_next;
      plate_ready_reg <= plate_ready_next;
      rejeitada_reg   <= rejeitada_next;
    end
  end

  relogio_semana #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT),
    .DAY_LEN       (DAY_LEN)
  ) u_relogio (
    .clk  (clk),
    .rst_n(rst_n),
    .tempo(tempo_w),
    .dias (dias_w)
  );

  assign bus.matricula   = matricula_reg;
  assign bus.barreira    = barreira_reg;
  assign bus.plate_ready = plate_ready_reg;
  assign bus.rejeitada   = rejeitada_reg;
  assign bus.tempo       = tempo_w;
  assign bus.dias        = dias_w;

endmodule

// File: tb/tb_controlo_barreira.sv
// Directed bench for controlo_barreira: week clock, passage, rejection,
// tailgating, OPEN timeout (OPEN_TIMEOUT_EN) and asynchronous reset.
module tb_controlo_barreira;
  import parque_pkg::*;

  localparam int TPU = 4;
  localparam int DL  = 96;
  localparam int OH  = 3;
  localparam int OT  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  controlo_barreira_if bus();

  controlo_barreira #(
    .TICKS_PER_UNIT(TPU),
    .DAY_LEN       (DL),
    .OPEN_HOLD     (OH),
    .OPEN_TIMEOUT  (OT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Present one plate read for a single cycle; returns one negedge after the sampling edge.
  task automatic aceitar(input logic [PLATE_W-1:0] p);
    bus.plate_valid = 1'b1;
    bus.plate_in    = p;
    @(negedge clk);
    bus.plate_valid = 1'b0;
    bus.plate_in    = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.plate_valid = 1'b0; bus.plate_in = '0; bus.sensor = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL reset_barreira actual=%0b required=1", bus.barreira); end
    checks++; if (bus.matricula !== 24'h0) begin errors++; $display("FAIL reset_matricula actual=%h required=000000", bus.matricula); end
    checks++; if (bus.tempo !== 7'd0) begin errors++; $display("FAIL reset_tempo actual=%0d required=0", bus.tempo); end
    checks++; if (bus.dias !== 3'd1) begin errors++; $display("FAIL reset_dias actual=%0d required=1", bus.dias); end
    checks++; if (bus.plate_ready !== 1'b1) begin errors++; $display("FAIL reset_plate_ready actual=%0b required=1", bus.plate_ready); end
    checks++; if (bus.rejeitada !== 1'b0) begin errors++; $display("FAIL reset_rejeitada actual=%0b required=0", bus.rejeitada); end
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_relogio;
    repeat (3) @(negedge clk);
    checks++; if (bus.tempo !== 7'd0) begin errors++; $display("FAIL clk_tempo_3 actual=%0d required=0", bus.tempo); end
    @(negedge clk);
    checks++; if (bus.tempo !== 7'd1) begin errors++; $display("FAIL clk_tempo_4 actual=%0d required=1", bus.tempo); end
    repeat (379) @(negedge clk);
    checks++; if (bus.tempo !== 7'd95 || bus.dias !== 3'd1) begin errors++; $display("FAIL clk_end_day actual=%0d/%0d required=95/1", bus.tempo, bus.dias); end
    @(negedge clk);
    checks++; if (bus.tempo !== 7'd0 || bus.dias !== 3'd2) begin errors++; $display("FAIL clk_day_wrap actual=%0d/%0d required=0/2", bus.tempo, bus.dias); end
    repeat (6 * TPU * DL) @(negedge clk);
    checks++; if (bus.tempo !== 7'd0 || bus.dias !== 3'd1) begin errors++; $display("FAIL clk_week_wrap actual=%0d/%0d required=0/1", bus.tempo, bus.dias); end
    $display("relogio: one week elapsed, tempo=%0d dias=%0d", bus.tempo, bus.dias);
  endtask

  task automatic test_passage;
    aceitar(24'hA1B2C3);
    checks++; if (bus.matricula !== 24'hA1B2C3) begin errors++; $display("FAIL pass_matricula actual=%h required=a1b2c3", bus.matricula); end
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL pass_open actual=%0b required=0", bus.barreira); end
    checks++; if (bus.plate_ready !== 1'b0) begin errors++; $display("FAIL pass_ready actual=%0b required=0", bus.plate_ready); end
    bus.sensor = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL pass_sensor_open actual=%0b required=0", bus.barreira); end
    bus.sensor = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL pass_hold_open actual=%0b required=0", bus.barreira); end
    @(negedge clk);
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL pass_closed actual=%0b required=1", bus.barreira); end
    checks++; if (bus.plate_ready !== 1'b1) begin errors++; $display("FAIL pass_ready_back actual=%0b required=1", bus.plate_ready); end
    $display("passage: plate a1b2c3 through");
  endtask

  task automatic test_zero_plate;
    aceitar(24'h000000);
    checks++; if (bus.rejeitada !== 1'b1) begin errors++; $display("FAIL zero_pulse actual=%0b required=1", bus.rejeitada); end
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL zero_barreira actual=%0b required=1", bus.barreira); end
    checks++; if (bus.matricula !== 24'hA1B2C3) begin errors++; $display("FAIL zero_matricula actual=%h required=a1b2c3", bus.matricula); end
    @(negedge clk);
    checks++; if (bus.rejeitada !== 1'b0) begin errors++; $display("FAIL zero_pulse_end actual=%0b required=0", bus.rejeitada); end
    $display("zero_plate: refused");
  endtask

  task automatic test_tailgate;
    aceitar(24'h123456);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL tg_open actual=%0b required=0", bus.barreira); end
    bus.sensor = 1'b1;
    @(negedge clk);
    aceitar(24'hFFFFFF);
    checks++; if (bus.matricula !== 24'h123456) begin errors++; $display("FAIL tg_ignore_plate actual=%h required=123456", bus.matricula); end
    aceitar(24'h000000);
    checks++; if (bus.rejeitada !== 1'b0) begin errors++; $display("FAIL tg_ignore_zero actual=%0b required=0", bus.rejeitada); end
    bus.sensor = 1'b0;
    repeat (2) @(negedge clk);
    bus.sensor = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL tg_reentry_open actual=%0b required=0", bus.barreira); end
    bus.sensor = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL tg_full_hold actual=%0b required=0", bus.barreira); end
    // Strobe lands on the edge that returns to IDLE, so it must be dropped.
    aceitar(24'h777777);
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL tg_closed actual=%0b required=1", bus.barreira); end
    checks++; if (bus.matricula !== 24'h123456) begin errors++; $display("FAIL tg_entry_edge_plate actual=%h required=123456", bus.matricula); end
    checks++; if (bus.plate_ready !== 1'b1) begin errors++; $display("FAIL tg_ready actual=%0b required=1", bus.plate_ready); end
    $display("tailgate: plate 123456 through with re-entry");
  endtask

  task automatic test_timeout;
    aceitar(24'hABCDEF);
`ifdef OPEN_TIMEOUT_EN
    repeat (OT - 1) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL to_before actual=%0b required=0", bus.barreira); end
    @(negedge clk);
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL to_closed actual=%0b required=1", bus.barreira); end
    checks++; if (bus.plate_ready !== 1'b1) begin errors++; $display("FAIL to_ready actual=%0b required=1", bus.plate_ready); end
    checks++; if (bus.matricula !== 24'hABCDEF) begin errors++; $display("FAIL to_matricula actual=%h required=abcdef", bus.matricula); end
    $display("timeout: abandoned plate abcdef closed after %0d cycles", OT);
`else
    repeat (1000) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL nto_open actual=%0b required=0", bus.barreira); end
    checks++; if (bus.plate_ready !== 1'b0) begin errors++; $display("FAIL nto_ready actual=%0b required=0", bus.plate_ready); end
    bus.sensor = 1'b1;
    @(negedge clk);
    bus.sensor = 1'b0;
    repeat (OH + 2) @(negedge clk);
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL nto_closed actual=%0b required=1", bus.barreira); end
    $display("timeout: disabled, OPEN held 1000 cycles");
`endif
  endtask

  task automatic test_reset_mid;
    aceitar(24'h0F0F0F);
    bus.sensor = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.barreira !== 1'b0) begin errors++; $display("FAIL rm_passing actual=%0b required=0", bus.barreira); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.barreira !== 1'b1) begin errors++; $display("FAIL rm_barreira actual=%0b required=1", bus.barreira); end
    checks++; if (bus.matricula !== 24'h0) begin errors++; $display("FAIL rm_matricula actual=%h required=000000", bus.matricula); end
    checks++; if (bus.tempo !== 7'd0 || bus.dias !== 3'd1) begin errors++; $display("FAIL rm_clock actual=%0d/%0d required=0/1", bus.tempo, bus.dias); end
    checks++; if (bus.plate_ready !== 1'b1) begin errors++; $display("FAIL rm_ready actual=%0b required=1", bus.plate_ready); end
    bus.sensor = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset_mid: barrier closed asynchronously");
  endtask

  initial begin
    test_reset();
    test_relogio();
    test_passage();
    test_zero_plate();
    test_tailgate();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
